// File: rtl/ov1_pkg.sv
// Shared types and constants for the OV1 CPLD routing sequencer.
package ov1_pkg;

  typedef enum logic [2:0] {
    ST_OFF         = 3'd0,
    ST_PWR_UP      = 3'd1,
    ST_READY       = 3'd2,
    ST_ROUTE_FPGA  = 3'd3,
    ST_ROUTE_XCORE = 3'd4,
    ST_GAP         = 3'd5,
    ST_PWR_DOWN    = 3'd6
  } state_e;

  // Positions of the used bits on the raw DIP bus.
  localparam int unsigned DIP_EN      = 0;
  localparam int unsigned DIP_PWR     = 1;
  localparam int unsigned DIP_JTAGEN  = 4;
  localparam int unsigned DIP_JTAGSEL = 5;

  // Positions of the same bits on the packed debounced bus.
  localparam int unsigned DB_W       = 4;
  localparam int unsigned DB_EN      = 0;
  localparam int unsigned DB_PWR     = 1;
  localparam int unsigned DB_JTAGEN  = 2;
  localparam int unsigned DB_JTAGSEL = 3;

  typedef enum logic [1:0] {
    TGT_NONE  = 2'd0,
    TGT_FPGA  = 2'd1,
    TGT_XCORE = 2'd2
  } tgt_e;

  // An FPGA request only counts while the FPGA is actually powered.
  function automatic tgt_e tgt_decode(input logic jtagen, input logic jtagsel,
                                      input logic powered);
    if (!jtagen) return TGT_NONE;
    if (jtagsel) return powered ? TGT_FPGA : TGT_NONE;
    return TGT_XCORE;
  endfunction

endpackage

// File: rtl/ov1_dip_debounce.sv
// Two-flop synchronizer plus per-bit debounce counter for asynchronous DIP inputs.
module ov1_dip_debounce #(
  parameter int unsigned W               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 65000,
  parameter int unsigned CW              = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [W-1:0]  sync1_q, sync1_d;
  logic [W-1:0]  sync2_q, sync2_d;
  logic [W-1:0]  deb_q, deb_d;
  logic [CW-1:0] cnt_q [W];
  logic [CW-1:0] cnt_d [W];

  // A bit flips only after it has disagreed with the accepted value for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < int'(W); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] >= CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < int'(W); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < int'(W); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/ov1_route_seq.sv
// OV1 power and JTAG routing sequencer: debounced DIPs drive FPGA power-up/down
// with settle delays and break-before-make switching of the FTDI JTAG target.
module ov1_route_seq #(
  parameter int unsigned DEBOUNCE_CYCLES   = 65000,
  parameter int unsigned PWR_SETTLE_CYCLES = 130000,
  parameter int unsigned GAP_CYCLES        = 16,
  parameter int unsigned CW                = 18
) (
  input  logic       clk13m,
  input  logic       reset,
  input  logic [6:0] dipsw_t,
  output logic       fpga_ven,
  output logic       fpga_mode_en,
  output logic       route_fpga,
  output logic       route_xcore,
  output logic       busy,
  output logic [2:0] state_dbg
);

  import ov1_pkg::*;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(PWR_SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  logic [DB_W-1:0] dip_raw, dip_deb;
  logic            unused_dips;
  logic            en, pwr;
  tgt_e            tgt;
  logic            pwr_change;

  state_e          state_q, state_d;
  logic            powered_q, powered_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            counting;

  assign dip_raw     = {dipsw_t[DIP_JTAGSEL], dipsw_t[DIP_JTAGEN],
                        dipsw_t[DIP_PWR], dipsw_t[DIP_EN]};
  assign unused_dips = ^{dipsw_t[6], dipsw_t[3:2]};

  ov1_dip_debounce #(
    .W               (DB_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CW              (CW)
  ) u_dip_debounce (
    .clk   (clk13m),
    .reset (reset),
    .din   (dip_raw),
    .dout  (dip_deb)
  );

  assign en         = dip_deb[DB_EN];
  assign pwr        = dip_deb[DB_PWR];
  assign tgt        = tgt_decode(dip_deb[DB_JTAGEN], dip_deb[DB_JTAGSEL], powered_q);
  assign pwr_change = (pwr != powered_q);

  // Next state: power requests win over routing; routes are only left via GAP.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:    state_d = pwr ? ST_PWR_UP : ST_READY;
        ST_PWR_UP,
        ST_PWR_DOWN: begin
          if (cnt_q >= SETTLE_LAST) state_d = ST_READY;
        end
        ST_READY: begin
          if (!pwr && powered_q)      state_d = ST_PWR_DOWN;
          else if (pwr && !powered_q) state_d = ST_PWR_UP;
          else if (tgt == TGT_FPGA)   state_d = ST_ROUTE_FPGA;
          else if (tgt == TGT_XCORE)  state_d = ST_ROUTE_XCORE;
        end
        ST_ROUTE_FPGA: begin
          if (tgt != TGT_FPGA || pwr_change) state_d = ST_GAP;
        end
        ST_ROUTE_XCORE: begin
          if (tgt != TGT_XCORE || pwr_change) state_d = ST_GAP;
        end
        ST_GAP: begin
          if (cnt_q >= GAP_LAST) state_d = ST_READY;
        end
        default:   state_d = ST_OFF;
      endcase
    end
  end

  // Power flag follows the state being entered; the shared counter clears on entry.
  always_comb begin
    powered_d = powered_q;
    if (state_d == ST_PWR_UP)                               powered_d = 1'b1;
    else if (state_d == ST_OFF || state_d == ST_PWR_DOWN)   powered_d = 1'b0;

    counting = (state_q == ST_PWR_UP) || (state_q == ST_PWR_DOWN) || (state_q == ST_GAP);
    cnt_d    = '0;
    if (state_d == state_q && counting) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk13m) begin
    if (reset) begin
      state_q   <= ST_OFF;
      powered_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      powered_q <= powered_d;
      cnt_q     <= cnt_d;
    end
  end

  // Moore decode of the registered state.
  always_comb begin
    fpga_ven     = powered_q;
    fpga_mode_en = powered_q && (state_q != ST_PWR_DOWN);
    route_fpga   = (state_q == ST_ROUTE_FPGA);
    route_xcore  = (state_q == ST_ROUTE_XCORE);
    busy         = (state_q == ST_PWR_UP) || (state_q == ST_GAP) || (state_q == ST_PWR_DOWN);
    state_dbg    = state_q;
  end

endmodule
